// File: rtl/burst_bus_pkg.sv
// Shared definitions for the DMA burst bus: responder FSM encoding, beat counter width
// and the abort priority ranking agreed with the newDMA initiator.
package burst_bus_pkg;

    localparam int unsigned BeatCountWidth = 8;

    // Abort priority ranking, lower value wins; newDMA resolves aborts in the same order.
    localparam int unsigned PrioReset    = 0;
    localparam int unsigned PrioBusError = 1;
    localparam int unsigned PrioEndTrans = 2;
    localparam int unsigned PrioBeat     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadFill,
        StRead,
        StReadEnd,
        StError,
        StDrain
    } state_e;

endpackage

// File: rtl/sram_sp_be.sv
// Single-port synchronous SRAM, 32 bits wide, with per-byte write enables.
// The read register only updates while i_read_en is high, so data holds across stalls.
module sram_sp_be #(
    parameter int unsigned AddrBits = 9
) (
    input  logic                i_clock,
    input  logic                i_read_en,
    input  logic [3:0]          i_write_en,
    input  logic [AddrBits-1:0] i_addr,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata
);

    localparam int unsigned Depth = 2 ** AddrBits;

    logic [31:0] r_mem [Depth];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clock) begin
        for (int b = 0; b < 4; b++) begin
            if (i_write_en[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_read_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_ram_responder.sv
// DMA burst bus responder backed by a local single-port SRAM: decodes begin requests,
// sinks write bursts, sources read bursts with initiator stalls and flags bad requests.
module burst_ram_responder
    import burst_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned ADDRESS_BITS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic [31:0] address_data_in,
    input  logic        read_n_write_in,
    input  logic [7:0]  burst_size_in,
    input  logic [3:0]  byte_enables_in,
    input  logic        data_valid_in,
    input  logic        busy_in,
    input  logic        end_transaction_in,
    input  logic        bus_error_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int unsigned SumBits = ADDRESS_BITS + 1;

    state_e                    r_state, w_state_next;
    logic [ADDRESS_BITS-1:0]   r_addr, w_addr_next;
    logic [BeatCountWidth-1:0] r_remaining, w_remaining_next;
    logic [3:0]                r_be, w_be_next;
    logic                      r_done, w_done_next;

    logic                    w_selected;
    logic                    w_misaligned;
    logic                    w_overflow;
    logic [ADDRESS_BITS-1:0] w_begin_word;
    logic [SumBits-1:0]      w_last_word;
    logic [ADDRESS_BITS-1:0] w_addr_inc;
    logic                    w_accept;
    logic                    w_write_beat;
    logic                    w_sram_re;
    logic [3:0]              w_sram_we;
    logic [ADDRESS_BITS-1:0] w_sram_addr;
    logic [31:0]             w_sram_rdata;

    assign w_selected   = address_data_in[31:ADDRESS_BITS+2] == BASE_ADDRESS[31:ADDRESS_BITS+2];
    assign w_misaligned = |address_data_in[1:0];
    assign w_begin_word = address_data_in[ADDRESS_BITS+1:2];
    // Widened by one bit so a burst running off the top of the window cannot wrap.
    assign w_last_word  = SumBits'(w_begin_word) + SumBits'(burst_size_in);
    assign w_overflow   = w_last_word > SumBits'({ADDRESS_BITS{1'b1}});
    assign w_addr_inc   = r_addr + ADDRESS_BITS'(1);

    assign w_accept     = (r_state == StRead) && !busy_in;
    assign w_write_beat = (r_state == StWrite) && data_valid_in && !r_done && !bus_error_in;
    assign w_sram_we    = w_write_beat ? r_be : 4'b0000;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_be        <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_next;
            r_be        <= w_be_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        w_be_next        = r_be;
        w_done_next      = r_done;
        w_sram_re        = 1'b0;
        w_sram_addr      = r_addr;

        unique case (r_state)
            StIdle: begin
                if (begin_transaction_in && w_selected) begin
                    w_addr_next      = w_begin_word;
                    w_remaining_next = burst_size_in;
                    w_be_next        = byte_enables_in;
                    w_done_next      = 1'b0;
                    if (w_misaligned || w_overflow) begin
                        w_state_next = StError;
                    end else if (read_n_write_in) begin
                        w_state_next = StReadFill;
                    end else begin
                        w_state_next = StWrite;
                    end
                end
            end
            StWrite: begin
                if (w_write_beat) begin
                    if (r_remaining == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_addr_next      = w_addr_inc;
                        w_remaining_next = r_remaining - BeatCountWidth'(1);
                    end
                end
            end
            StReadFill: begin
                w_sram_re    = 1'b1;
                w_state_next = StRead;
            end
            StRead: begin
                // Fetch the next word on acceptance so it appears in the following cycle.
                if (w_accept) begin
                    if (r_remaining == '0) begin
                        w_state_next = StReadEnd;
                    end else begin
                        w_sram_re        = 1'b1;
                        w_sram_addr      = w_addr_inc;
                        w_addr_next      = w_addr_inc;
                        w_remaining_next = r_remaining - BeatCountWidth'(1);
                    end
                end
            end
            StReadEnd: w_state_next = StIdle;
            StError:   w_state_next = StDrain;
            StDrain:   w_state_next = StDrain;
            default:   w_state_next = StIdle;
        endcase

        if (end_transaction_in && (r_state != StIdle)) begin
            w_state_next = StIdle;
        end
        if (bus_error_in) begin
            w_state_next = StIdle;
        end
    end

    sram_sp_be #(
        .AddrBits (ADDRESS_BITS)
    ) u_sram (
        .i_clock    (clock),
        .i_read_en  (w_sram_re),
        .i_write_en (w_sram_we),
        .i_addr     (w_sram_addr),
        .i_wdata    (address_data_in),
        .o_rdata    (w_sram_rdata)
    );

    assign data_valid_out      = r_state == StRead;
    assign address_data_out    = data_valid_out ? w_sram_rdata : 32'h0;
    assign end_transaction_out = r_state == StReadEnd;
    assign busy_out            = (r_state == StReadFill) || (r_state == StError);
    assign error_out           = r_state == StError;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder: directed scenarios plus randomized
// write/read bursts checked against a word-array model of the responder memory.
module tb_burst_ram_responder;

    localparam int unsigned Words = 512;
    localparam logic [31:0] Base  = 32'h5000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        begin_transaction_in;
    logic [31:0] address_data_in;
    logic        read_n_write_in;
    logic [7:0]  burst_size_in;
    logic [3:0]  byte_enables_in;
    logic        data_valid_in;
    logic        busy_in;
    logic        end_transaction_in;
    logic        bus_error_in;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [Words];

    always #5 clock = ~clock;

    burst_ram_responder #(
        .BASE_ADDRESS (Base),
        .ADDRESS_BITS (9)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .begin_transaction_in(begin_transaction_in),
        .address_data_in     (address_data_in),
        .read_n_write_in     (read_n_write_in),
        .burst_size_in       (burst_size_in),
        .byte_enables_in     (byte_enables_in),
        .data_valid_in       (data_valid_in),
        .busy_in             (busy_in),
        .end_transaction_in  (end_transaction_in),
        .bus_error_in        (bus_error_in),
        .address_data_out    (address_data_out),
        .data_valid_out      (data_valid_out),
        .end_transaction_out (end_transaction_out),
        .busy_out            (busy_out),
        .error_out           (error_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        begin_transaction_in = 1'b0;
        address_data_in      = 32'h0;
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'h0;
        byte_enables_in      = 4'h0;
        data_valid_in        = 1'b0;
        busy_in              = 1'b0;
        end_transaction_in   = 1'b0;
        bus_error_in         = 1'b0;
    endtask

    function automatic logic [31:0] addr_of(int word);
        return Base + 32'(word * 4);
    endfunction

    function automatic void model_write(int word, logic [3:0] be, logic [31:0] d[$]);
        for (int i = 0; i < d.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[word + i][8*b +: 8] = d[i][8*b +: 8];
            end
        end
    endfunction

    // Drives a full write burst; end_transaction_in lands with or after the last beat.
    task automatic write_burst(input int word, input logic [3:0] be, input logic [31:0] d[$],
                               input bit random_gaps);
        begin_transaction_in = 1'b1;
        address_data_in      = addr_of(word);
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'(d.size() - 1);
        byte_enables_in      = be;
        tick();
        begin_transaction_in = 1'b0;
        for (int i = 0; i < d.size(); i++) begin
            if (random_gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    data_valid_in   = 1'b0;
                    address_data_in = $urandom;
                    tick();
                end
            end
            data_valid_in      = 1'b1;
            address_data_in    = d[i];
            end_transaction_in = (i == d.size() - 1) && (!random_gaps || $urandom_range(0, 1) == 1);
            tick();
        end
        data_valid_in   = 1'b0;
        address_data_in = 32'h0;
        if (!end_transaction_in) begin
            end_transaction_in = 1'b1;
            tick();
        end
        end_transaction_in = 1'b0;
    endtask

    // Runs a read burst. mode 0: no stalls, 1: beats 1 and 2 stalled 2 cycles each,
    // 2: random stalls. Cycle numbers are relative to the begin cycle (0).
    task automatic read_burst(input int word, input int bs, input int mode,
                              output logic [31:0] data[$], output int busy1,
                              output int first_valid, output int end_cyc, output int stalls,
                              output int unstable, output int err_seen, output bit timeout);
        int cyc;
        int beat;
        int stall_left;
        bit holding;
        logic [31:0] held;
        data = {};
        first_valid = -1;
        end_cyc = -1;
        stalls = 0;
        unstable = 0;
        err_seen = 0;
        beat = 0;
        stall_left = 0;
        holding = 1'b0;
        held = 32'h0;
        begin_transaction_in = 1'b1;
        address_data_in      = addr_of(word);
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'(bs);
        byte_enables_in      = 4'hF;
        tick();
        begin_transaction_in = 1'b0;
        address_data_in      = 32'h0;
        cyc = 1;
        busy1 = int'(busy_out);
        while (end_cyc < 0 && cyc < 2000) begin
            if (error_out) err_seen++;
            if (end_transaction_out) end_cyc = cyc;
            busy_in = 1'b0;
            if (holding && (!data_valid_out || address_data_out !== held)) unstable++;
            if (data_valid_out) begin
                if (first_valid < 0) first_valid = cyc;
                if (!holding) begin
                    if (mode == 1) stall_left = (beat == 1 || beat == 2) ? 2 : 0;
                    else if (mode == 2)
                        stall_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    else stall_left = 0;
                end
                if (stall_left > 0) begin
                    busy_in = 1'b1;
                    stall_left--;
                    stalls++;
                    holding = 1'b1;
                    held = address_data_out;
                end else begin
                    data.push_back(address_data_out);
                    beat++;
                    holding = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        busy_in = 1'b0;
        timeout = (end_cyc < 0);
    endtask

    task automatic test_reset();
        checks++; if (data_valid_out !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", data_valid_out); end
        checks++; if (address_data_out !== 32'h0) begin errors++;
            $display("FAIL reset_data: got %h want 0", address_data_out); end
        checks++; if (end_transaction_out !== 1'b0) begin errors++;
            $display("FAIL reset_end: got %b want 0", end_transaction_out); end
        checks++; if (busy_out !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (error_out !== 1'b0) begin errors++;
            $display("FAIL reset_error: got %b want 0", error_out); end
    endtask

    task automatic fill_memory();
        logic [31:0] d[$];
        for (int half = 0; half < 2; half++) begin
            d = {};
            for (int i = 0; i < 256; i++) d.push_back($urandom);
            write_burst(half * 256, 4'hF, d, 1'b0);
            model_write(half * 256, 4'hF, d);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d[$];
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        d = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        write_burst(4, 4'hF, d, 1'b0);
        model_write(4, 4'hF, d);
        read_burst(4, 3, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || busy1 != 1) begin errors++;
            $display("FAIL wr_busy1: got busy=%0d timeout=%0d want 1/0", busy1, to); end
        checks++; if (fv != 2) begin errors++;
            $display("FAIL wr_first_valid: got cycle %0d want 2", fv); end
        checks++; if (ec != 6) begin errors++;
            $display("FAIL wr_end: got cycle %0d want 6", ec); end
        checks++; if (got.size() != 4) begin errors++;
            $display("FAIL wr_beats: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== 32'hA0 + 32'(i)) begin errors++;
                $display("FAIL wr_data[%0d]: got %h want %h", i, got[i], 32'hA0 + 32'(i)); end
        end
    endtask

    task automatic test_read_stalls();
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        read_burst(4, 3, 1, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || ec != 10) begin errors++;
            $display("FAIL stall_end: got cycle %0d want 10", ec); end
        checks++; if (un != 0) begin errors++;
            $display("FAIL stall_stable: got %0d unstable cycles want 0", un); end
        checks++; if (got.size() != 4) begin errors++;
            $display("FAIL stall_beats: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== 32'hA0 + 32'(i)) begin errors++;
                $display("FAIL stall_data[%0d]: got %h want %h", i, got[i], 32'hA0 + 32'(i)); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        // Window overflow: 0x1FF + 1 runs past the last word.
        begin_transaction_in = 1'b1;
        address_data_in      = 32'h5000_07FC;
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'd1;
        byte_enables_in      = 4'hF;
        tick();
        begin_transaction_in = 1'b0;
        checks++; if (error_out !== 1'b1 || busy_out !== 1'b1) begin errors++;
            $display("FAIL ovf_error: got err=%b busy=%b want 1/1", error_out, busy_out); end
        data_valid_in   = 1'b1;
        address_data_in = 32'hDEAD_BEEF;
        tick();
        checks++; if (error_out !== 1'b0 || busy_out !== 1'b0) begin errors++;
            $display("FAIL ovf_pulse: got err=%b busy=%b want 0/0", error_out, busy_out); end
        tick();
        data_valid_in      = 1'b0;
        end_transaction_in = 1'b1;
        tick();
        end_transaction_in = 1'b0;
        read_burst(511, 0, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || ec != 3 || got.size() != 1) begin errors++;
            $display("FAIL ovf_idle: got end=%0d beats=%0d want 3/1", ec, got.size()); end
        checks++; if (got.size() < 1 || got[0] !== model_mem[511]) begin errors++;
            $display("FAIL ovf_nowrite: got %h want %h", got.size() ? got[0] : 32'hx,
                     model_mem[511]); end
        // Misaligned address.
        begin_transaction_in = 1'b1;
        address_data_in      = 32'h5000_0002;
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'd0;
        tick();
        begin_transaction_in = 1'b0;
        checks++; if (error_out !== 1'b1) begin errors++;
            $display("FAIL misalign_error: got %b want 1", error_out); end
        tick();
        checks++; if (error_out !== 1'b0 || data_valid_out !== 1'b0) begin errors++;
            $display("FAIL misalign_drain: got err=%b valid=%b want 0/0", error_out,
                     data_valid_out); end
        end_transaction_in = 1'b1;
        tick();
        end_transaction_in = 1'b0;
        // Exactly reaching the last word is legal.
        read_burst(508, 3, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (es != 0 || to || got.size() != 4) begin errors++;
            $display("FAIL top_edge: got err_cycles=%0d beats=%0d want 0/4", es, got.size()); end
        checks++; if (got.size() < 4 || got[3] !== model_mem[511]) begin errors++;
            $display("FAIL top_edge_data: got %h want %h", got.size() > 3 ? got[3] : 32'hx,
                     model_mem[511]); end
    endtask

    task automatic test_unselected();
        logic [31:0] addrs [2];
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        addrs[0] = 32'h4000_0000;
        addrs[1] = 32'h5000_0800;
        for (int a = 0; a < 2; a++) begin
            begin_transaction_in = 1'b1;
            address_data_in      = addrs[a];
            read_n_write_in      = 1'(a);
            burst_size_in        = 8'd0;
            byte_enables_in      = 4'hF;
            tick();
            begin_transaction_in = 1'b0;
            for (int c = 0; c < 4; c++) begin
                data_valid_in      = 1'b1;
                address_data_in    = 32'h0BAD_0BAD;
                end_transaction_in = (c == 3);
                checks++;
                if ({data_valid_out, end_transaction_out, busy_out, error_out} !== 4'b0 ||
                    address_data_out !== 32'h0) begin
                    errors++;
                    $display("FAIL unsel_outputs[%0d]: got v=%b e=%b b=%b err=%b d=%h want all 0",
                             a, data_valid_out, end_transaction_out, busy_out, error_out,
                             address_data_out);
                end
                tick();
            end
            idle_inputs();
        end
        read_burst(0, 0, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || got.size() != 1 || got[0] !== model_mem[0]) begin errors++;
            $display("FAIL unsel_mem: got %h want %h", got.size() ? got[0] : 32'hx,
                     model_mem[0]); end
    endtask

    task automatic test_bus_error();
        int valid_seen;
        int cyc;
        logic [31:0] got[$];
        valid_seen = 0;
        cyc = 0;
        begin_transaction_in = 1'b1;
        address_data_in      = addr_of(100);
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'd4;
        tick();
        begin_transaction_in = 1'b0;
        while (valid_seen < 3 && cyc < 20) begin
            if (data_valid_out) begin
                valid_seen++;
                if (valid_seen < 3) got.push_back(address_data_out);
            end
            bus_error_in = (valid_seen == 3);
            tick();
            cyc++;
        end
        bus_error_in = 1'b0;
        checks++; if (valid_seen != 3) begin errors++;
            $display("FAIL abort_reach: got %0d beats want 3", valid_seen); end
        checks++; if (data_valid_out !== 1'b0 || address_data_out !== 32'h0 ||
                      end_transaction_out !== 1'b0 || busy_out !== 1'b0) begin errors++;
            $display("FAIL abort_outputs: got v=%b d=%h e=%b b=%b want 0", data_valid_out,
                     address_data_out, end_transaction_out, busy_out); end
        checks++; if (got.size() != 2 || got[0] !== model_mem[100] || got[1] !== model_mem[101])
            begin errors++;
            $display("FAIL abort_data: got %0d beats want %h %h", got.size(), model_mem[100],
                     model_mem[101]); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] d[$];
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        d = {$urandom, $urandom};
        begin_transaction_in = 1'b1;
        address_data_in      = addr_of(200);
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'd3;
        byte_enables_in      = 4'hF;
        tick();
        begin_transaction_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_valid_in   = 1'b1;
            address_data_in = d[i];
            tick();
        end
        model_write(200, 4'hF, d);
        #2 reset = 1'b0;
        data_valid_in = 1'b0;
        #1;
        checks++; if ({data_valid_out, end_transaction_out, busy_out, error_out} !== 4'b0)
            begin errors++;
            $display("FAIL rst_write_outputs: got v=%b e=%b b=%b err=%b want 0", data_valid_out,
                     end_transaction_out, busy_out, error_out); end
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        read_burst(200, 3, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || got.size() != 4) begin errors++;
            $display("FAIL rst_restart: got %0d beats want 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== model_mem[200 + i]) begin errors++;
                $display("FAIL rst_retain[%0d]: got %h want %h", i, got[i], model_mem[200 + i]);
            end
        end
        // Reset while a read beat is on the bus drops it without a clock edge.
        begin_transaction_in = 1'b1;
        address_data_in      = addr_of(200);
        read_n_write_in      = 1'b1;
        burst_size_in        = 8'd3;
        tick();
        begin_transaction_in = 1'b0;
        tick();
        checks++; if (data_valid_out !== 1'b1) begin errors++;
            $display("FAIL rst_read_valid: got %b want 1", data_valid_out); end
        #2 reset = 1'b0;
        #1;
        checks++; if (data_valid_out !== 1'b0 || address_data_out !== 32'h0) begin errors++;
            $display("FAIL rst_read_outputs: got v=%b d=%h want 0", data_valid_out,
                     address_data_out); end
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_enables();
        logic [31:0] d[$];
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        d = {32'h1234_5678};
        write_burst(300, 4'hF, d, 1'b0);
        model_write(300, 4'hF, d);
        d = {32'hFFFF_FFFF};
        write_burst(300, 4'b0101, d, 1'b0);
        model_write(300, 4'b0101, d);
        read_burst(300, 0, 0, got, busy1, fv, ec, st, un, es, to);
        checks++; if (to || got.size() != 1 || got[0] !== 32'h12FF_56FF) begin errors++;
            $display("FAIL byte_en: got %h want 12ff56ff", got.size() ? got[0] : 32'hx); end
    endtask

    task automatic test_random();
        logic [31:0] d[$];
        logic [31:0] got[$];
        int busy1, fv, ec, st, un, es;
        bit to;
        int bs, word;
        logic [3:0] be;
        for (int it = 0; it < 30; it++) begin
            bs   = int'($urandom_range(0, 15));
            word = int'($urandom_range(0, Words - 1 - bs));
            be   = 4'($urandom);
            d    = {};
            for (int i = 0; i <= bs; i++) d.push_back($urandom);
            write_burst(word, be, d, 1'b1);
            model_write(word, be, d);
            bs   = int'($urandom_range(0, 15));
            word = int'($urandom_range(0, Words - 1 - bs));
            read_burst(word, bs, 2, got, busy1, fv, ec, st, un, es, to);
            checks++; if (to || fv != 2 || ec != 3 + bs + st || es != 0 || un != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got first=%0d end=%0d err=%0d unstable=%0d want 2/%0d/0/0",
                         it, fv, ec, es, un, 3 + bs + st);
            end
            checks++; if (got.size() != bs + 1) begin errors++;
                $display("FAIL rand_beats[%0d]: got %0d want %0d", it, got.size(), bs + 1); end
            for (int i = 0; i < got.size() && i <= bs; i++) begin
                checks++; if (got[i] !== model_mem[word + i]) begin errors++;
                    $display("FAIL rand_data[%0d.%0d]: got %h want %h", it, i, got[i],
                             model_mem[word + i]); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        tick();
        fill_memory();
        test_write_read();
        test_read_stalls();
        test_errors();
        test_unselected();
        test_bus_error();
        test_reset_abort();
        test_byte_enables();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
